// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   UART serial transmitter. Accepts one parallel word and shifts it out as
//   start bit, DBIT data bits LSB-first, an optional parity bit and a stop
//   period of SB_TICK oversample ticks. Bit timing comes from the shared
//   16x baud tick.
// Parameters
//   DBIT     data bits per frame (5..9)
//   SB_TICK  ticks spent in the stop state (16/24/32 = 1/1.5/2 stop bits)
//   PARITY   0 = none, 1 = even, 2 = odd
// Ports
//   i_clk           system clock
//   i_rst           synchronous active-high reset
//   i_s_tick        1-cycle pulse at 16x the baud rate
//   i_tx_start      send request, honoured only while idle
//   i_din           word to send, captured on the accepting cycle
//   o_tx_busy       high while a frame is in flight
//   o_tx_done_tick  1-cycle pulse at the end of the stop period
//   o_tx            serial line, registered, idles high
module uart_tx_engine #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_s_tick,
  input  logic            i_tx_start,
  input  logic [DBIT-1:0] i_din,
  output logic            o_tx_busy,
  output logic            o_tx_done_tick,
  output logic            o_tx
);

  // Tick counter must reach both 15 and SB_TICK-1.
  localparam int SW = ($clog2(SB_TICK) < 4) ? 4 : $clog2(SB_TICK);
  localparam int NW = (DBIT <= 2) ? 1 : $clog2(DBIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_s_cnt;
  logic [NW-1:0]   r_n_cnt;
  logic [DBIT-1:0] r_shift;
  logic            r_par;
  logic            r_tx;
  logic            r_busy;
  logic            r_done;

  // Parity of the full word once the last data bit is folded in.
  logic w_par_acc;
  logic w_par_bit;
  assign w_par_acc = r_par ^ r_shift[0];
  assign w_par_bit = (PARITY == 2) ? ~w_par_acc : w_par_acc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          // A request coinciding with the done pulse is dropped; the source
          // re-presents it, which guarantees an idle-high gap between frames.
          if (i_tx_start && !r_done) begin
            r_shift <= i_din;
            r_par   <= 1'b0;
            r_s_cnt <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (i_s_tick) begin
            if (r_s_cnt == SW'(15)) begin
              r_s_cnt <= '0;
              r_n_cnt <= '0;
              r_tx    <= r_shift[0];
              r_state <= S_DATA;
            end else begin
              r_s_cnt <= r_s_cnt + SW'(1);
            end
          end
        end
        S_DATA: begin
          if (i_s_tick) begin
            if (r_s_cnt == SW'(15)) begin
              r_s_cnt <= '0;
              r_par   <= w_par_acc;
              r_shift <= r_shift >> 1;
              if (r_n_cnt == NW'(DBIT - 1)) begin
                if (PARITY != 0) begin
                  r_tx    <= w_par_bit;
                  r_state <= S_PAR;
                end else begin
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
                end
              end else begin
                r_n_cnt <= r_n_cnt + NW'(1);
                r_tx    <= r_shift[1];
              end
            end else begin
              r_s_cnt <= r_s_cnt + SW'(1);
            end
          end
        end
        S_PAR: begin
          if (i_s_tick) begin
            if (r_s_cnt == SW'(15)) begin
              r_s_cnt <= '0;
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_s_cnt <= r_s_cnt + SW'(1);
            end
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (i_s_tick) begin
            if (r_s_cnt == SW'(SB_TICK - 1)) begin
              r_s_cnt <= '0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_s_cnt <= r_s_cnt + SW'(1);
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_tx           = r_tx;
  assign o_tx_busy      = r_busy;
  assign o_tx_done_tick = r_done;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   = 1'b1;
  logic [3:0] start = '0;
  logic [7:0] din   = '0;
  logic [3:0] busy, done, tx;
  logic       s_tick;
  int         tcnt  = 0;
  int         cyc   = 0;
  int         n_tests = 0;
  int         n_fail  = 0;

  // Baud tick every 10 clocks.
  always @(posedge clk) begin
    tcnt <= (tcnt == 9) ? 0 : tcnt + 1;
    cyc  <= cyc + 1;
  end
  assign s_tick = (tcnt == 9);

  // u0: 8N1   u1: 8E1   u2: 8O1   u3: 7 data bits, 2 stop bits
  uart_tx_engine #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_s_tick(s_tick), .i_tx_start(start[0]),
    .i_din(din), .o_tx_busy(busy[0]), .o_tx_done_tick(done[0]), .o_tx(tx[0]));
  uart_tx_engine #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_s_tick(s_tick), .i_tx_start(start[1]),
    .i_din(din), .o_tx_busy(busy[1]), .o_tx_done_tick(done[1]), .o_tx(tx[1]));
  uart_tx_engine #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u2 (
    .i_clk(clk), .i_rst(rst), .i_s_tick(s_tick), .i_tx_start(start[2]),
    .i_din(din), .o_tx_busy(busy[2]), .o_tx_done_tick(done[2]), .o_tx(tx[2]));
  uart_tx_engine #(.DBIT(7), .SB_TICK(32), .PARITY(0)) u3 (
    .i_clk(clk), .i_rst(rst), .i_s_tick(s_tick), .i_tx_start(start[3]),
    .i_din(din[6:0]), .o_tx_busy(busy[3]), .o_tx_done_tick(done[3]), .o_tx(tx[3]));

  function automatic int dbit_of(int k); return (k == 3) ? 7 : 8; endfunction
  function automatic int par_of(int k);  return (k == 1) ? 1 : (k == 2) ? 2 : 0; endfunction
  function automatic int sb_of(int k);   return (k == 3) ? 32 : 16; endfunction

  typedef struct {
    int         k;        // which instance
    logic [7:0] d;        // word sent
    logic       exp_par;  // expected parity bit (if instance has parity)
    int         exp_len;  // clocks from start-bit edge to done pulse
  } vec_t;

  vec_t vecs[6];
  vec_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Call at a negedge; accepts on a tick cycle so the first START tick lands
  // 9 clocks into the start bit, giving exact 160-clock bits.
  task automatic launch(input int k, input logic [7:0] d);
    while (!s_tick) @(negedge clk);
    din      = d;
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    din      = 8'($urandom);
  endtask

  // Receiver model: waits for the start edge, samples every bit mid-way.
  // In aligned mode it also checks the first and last clock of each bit.
  task automatic rx_frame(input int k, input bit aligned, output logic [11:0] got,
                          output int t0, output int t_done, output bit edge_err,
                          output bit tmo);
    int nb, total, w, b, o, stop_at;
    logic [11:0] first, last;
    bit seen;
    nb      = 2 + dbit_of(k) + ((par_of(k) != 0) ? 1 : 0);
    stop_at = 160 * (nb - 1);
    total   = stop_at + 10 * sb_of(k);
    got = '1; first = '1; last = '1;
    edge_err = 0; tmo = 0; seen = 0; t0 = 0; t_done = 0; w = 0;
    while (tx[k] !== 1'b0 && w < 4000) begin @(negedge clk); w++; end
    if (w >= 4000) begin tmo = 1; return; end
    t0 = cyc;
    for (int c = 0; c < total; c++) begin
      if (c < stop_at) begin
        b = c / 160; o = c % 160;
        if (o == 80)  got[b]   = tx[k];
        if (o == 0)   first[b] = tx[k];
        if (o == 159) last[b]  = tx[k];
      end else begin
        if (c == stop_at + 5 * sb_of(k)) got[nb-1] = tx[k];
        if (tx[k] !== 1'b1) edge_err = 1;
      end
      if (c == 80 && busy[k] !== 1'b1) edge_err = 1;
      if (done[k] === 1'b1) begin seen = 1; t_done = cyc; break; end
      @(negedge clk);
    end
    w = 0;
    while (!seen && w < 40) begin
      if (done[k] === 1'b1) begin seen = 1; t_done = cyc; end
      else begin @(negedge clk); w++; end
    end
    if (!seen) tmo = 1;
    else if (busy[k] !== 1'b0) edge_err = 1;
    if (aligned)
      for (int i = 0; i < nb - 1; i++)
        if (first[i] !== got[i] || last[i] !== got[i]) edge_err = 1;
  endtask

  task automatic check_frame(input string tag, input vec_t v, input logic [11:0] got);
    int db;
    int pb;
    logic [7:0] data;
    db   = dbit_of(v.k);
    pb   = (par_of(v.k) != 0) ? 1 : 0;
    data = '0;
    for (int i = 0; i < db; i++) data[i] = got[1+i];
    check({tag, ".start"}, got[0], 0);
    check({tag, ".data"}, data, v.d);
    if (pb != 0) check({tag, ".parity"}, got[1+db], v.exp_par);
    check({tag, ".stop"}, got[1+db+pb], 1);
  endtask

  task automatic run_vec(input string tag, input vec_t vin);
    logic [11:0] got;
    int t0, td;
    bit ee, tmo;
    vec_t v;
    sb_q.push_back(vin);
    launch(vin.k, vin.d);
    rx_frame(vin.k, 1, got, t0, td, ee, tmo);
    v = sb_q.pop_front();
    check({tag, ".timeout"}, tmo, 0);
    check({tag, ".edges"}, ee, 0);
    check_frame(tag, v, got);
    check({tag, ".len"}, td - t0, v.exp_len);
    @(negedge clk);
    check({tag, ".done_pulse"}, done[v.k], 0);
  endtask

  initial begin
    logic [11:0] got;
    int t0, td, t0b, tdb, bad;
    bit ee, tmo;
    vec_t v;

    vecs[0] = '{0, 8'hA5, 1'b0, 1600};
    vecs[1] = '{1, 8'hA5, 1'b0, 1760};
    vecs[2] = '{1, 8'h01, 1'b1, 1760};
    vecs[3] = '{2, 8'hA5, 1'b1, 1760};
    vecs[4] = '{2, 8'h01, 1'b0, 1760};
    vecs[5] = '{3, 8'h7F, 1'b0, 1600};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset.tx%0d", k), tx[k], 1);
      check($sformatf("reset.busy%0d", k), busy[k], 0);
      check($sformatf("reset.done%0d", k), done[k], 0);
    end

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // tx_start held high: exactly two whole frames with an idle gap.
    sb_q.push_back('{0, 8'h55, 1'b0, 1600});
    sb_q.push_back('{0, 8'h0F, 1'b0, 1600});
    din = 8'h55; start[0] = 1'b1;
    fork
      begin : drv
        int w;
        w = 0; while (busy[0] !== 1'b1 && w < 100)  begin @(negedge clk); w++; end
        din = 8'h0F;
        w = 0; while (busy[0] !== 1'b0 && w < 3000) begin @(negedge clk); w++; end
        w = 0; while (busy[0] !== 1'b1 && w < 100)  begin @(negedge clk); w++; end
        start[0] = 1'b0;
      end
      begin : mon
        rx_frame(0, 0, got, t0, td, ee, tmo);
        v = sb_q.pop_front();
        check("b2b1.timeout", tmo, 0);
        check("b2b1.edges", ee, 0);
        check_frame("b2b1", v, got);
        rx_frame(0, 0, got, t0b, tdb, ee, tmo);
        v = sb_q.pop_front();
        check("b2b2.timeout", tmo, 0);
        check("b2b2.edges", ee, 0);
        check_frame("b2b2", v, got);
      end
    join
    check("b2b.gap", (t0b - td) >= 2, 1);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    check("b2b.no_third", bad, 0);

    // Start pulse with a new word mid-frame must be ignored.
    sb_q.push_back('{0, 8'h12, 1'b0, 1600});
    launch(0, 8'h12);
    fork
      rx_frame(0, 1, got, t0, td, ee, tmo);
      begin
        repeat (400) @(negedge clk);
        din = 8'hFF; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
      end
    join
    v = sb_q.pop_front();
    check("busy_ign.timeout", tmo, 0);
    check("busy_ign.edges", ee, 0);
    check_frame("busy_ign", v, got);
    check("busy_ign.len", td - t0, v.exp_len);

    // Reset during data bit 3.
    @(negedge clk);
    launch(0, 8'hC3);
    repeat (700) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid.tx", tx[0], 1);
    check("rst_mid.busy", busy[0], 0);
    bad = 0;
    repeat (2000) begin
      if (done[0] !== 1'b0 || tx[0] !== 1'b1) bad++;
      @(negedge clk);
    end
    check("rst_mid.quiet", bad, 0);
    run_vec("post_rst", '{0, 8'h3C, 1'b0, 1600});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
